// File: rtl/imem_loader_ctrl_pkg.sv
// Shared constants and types for the instruction-memory loader.
package imem_loader_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN
  } state_t;

  localparam int DEF_RAM_WIDTH = 32;
  localparam logic [DEF_RAM_WIDTH-1:0] DEF_END_MARKER = 32'hFFFF_FFFF;
  localparam int BYTES_PER_WORD = DEF_RAM_WIDTH / 8;

  // Number of bytes that make up one word of the given width.
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

  // Width of an index that counts 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_ctrl_if.sv
// Byte stream in / RAM write port out, grouped as one bundle.
// master = loader side, slave = UART receiver + RAM side.
interface imem_loader_ctrl_if #(
  parameter int RAM_WIDTH = 32,
  parameter int NB_DEPTH  = 10
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic [NB_DEPTH-1:0]  o_wr_addr;
  logic [RAM_WIDTH-1:0] o_wr_data;
  logic                 o_wea;
  logic                 o_regcea;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_wr_addr, o_wr_data, o_wea, o_regcea
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_wr_addr, o_wr_data, o_wea, o_regcea
  );
endinterface

// File: rtl/imem_loader_ctrl_byte_word_assembler.sv
// Packs a byte stream into words, first byte into the most significant lane.
// o_word/o_word_valid are combinational from the byte completing the word so
// the parent can register its write one cycle after that byte. RAM_WIDTH >= 16.
module imem_loader_ctrl_byte_word_assembler
  import imem_loader_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [7:0]           i_byte,
  input  logic                 i_byte_valid,
  output logic [RAM_WIDTH-1:0] o_word,
  output logic                 o_word_valid
);

  localparam int BPW   = bytes_per_word(RAM_WIDTH);
  localparam int IDX_W = idx_width(BPW);

  logic [RAM_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic [RAM_WIDTH-1:0] w_next;
  logic                 w_take;
  logic                 w_last;

  assign w_take       = i_byte_valid && !i_clear;
  assign w_last       = (r_idx == IDX_W'(BPW - 1));
  assign w_next       = {r_shift[RAM_WIDTH-9:0], i_byte};
  assign o_word       = w_next;
  assign o_word_valid = w_take && w_last;

  // Byte index: counts bytes of the word in progress, wraps after the last lane.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx <= '0;
    end else if (w_take) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Shift register: older bytes move toward the MSB; stale lanes are fully
  // overwritten before the next completed word is presented.
  always_ff @(posedge i_clk) begin
    if (w_take) begin
      r_shift <= w_next;
    end
  end

endmodule

// File: rtl/imem_loader_ctrl.sv
// Program-load sequencer for the instruction RAM: holds the CPU in reset
// while words arrive over the debug UART, writes them from address 0 up, and
// releases the CPU when the end marker arrives or the RAM is full.
module imem_loader_ctrl
  import imem_loader_ctrl_pkg::*;
#(
  parameter int                   RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int                   NB_DEPTH   = 10,
  parameter logic [RAM_WIDTH-1:0] END_MARKER = DEF_END_MARKER
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  imem_loader_ctrl_if.master   bus,
  output logic                 o_cpu_rst,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [NB_DEPTH:0]    o_word_count
);

  localparam logic [NB_DEPTH-1:0] ADDR_MAX = '1;

  state_t               r_state;
  logic [NB_DEPTH-1:0]  r_addr;
  logic [NB_DEPTH-1:0]  r_wr_addr;
  logic [RAM_WIDTH-1:0] r_wr_data;
  logic                 r_wea;
  logic                 r_regcea;
  logic                 r_cpu_rst;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [NB_DEPTH:0]    r_count;

  logic                 w_loading;
  logic                 w_byte_valid;
  logic [RAM_WIDTH-1:0] w_word;
  logic                 w_word_valid;

  // Bytes only count while loading; outside LOAD the assembler is held
  // cleared so every load starts on a word boundary.
  assign w_loading    = (r_state == S_LOAD);
  assign w_byte_valid = bus.i_rx_valid && w_loading;

  imem_loader_ctrl_byte_word_assembler #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (!w_loading),
    .i_byte       (bus.i_rx_data),
    .i_byte_valid (w_byte_valid),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Load FSM with address/count counters and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wea      <= 1'b0;
      r_regcea   <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_wea  <= 1'b0;
      r_done <= 1'b0;

      // Advance after each write; the address saturates at the top so a
      // load never wraps back over address 0.
      if (r_wea) begin
        r_count <= r_count + (NB_DEPTH+1)'(1);
        if (r_addr != ADDR_MAX) begin
          r_addr <= r_addr + 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_RUN: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_cpu_rst  <= 1'b1;
            r_regcea   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_word_valid) begin
            if (w_word == END_MARKER) begin
              r_state   <= S_RUN;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_cpu_rst <= 1'b0;
              r_regcea  <= 1'b1;
            end else begin
              r_wea     <= 1'b1;
              r_wr_data <= w_word;
              r_wr_addr <= r_addr;
              // Last RAM location taken: finish the load as full.
              if (r_addr == ADDR_MAX) begin
                r_overflow <= 1'b1;
                r_state    <= S_RUN;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_cpu_rst  <= 1'b0;
                r_regcea   <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_wea     = r_wea;
  assign bus.o_regcea  = r_regcea;
  assign o_cpu_rst     = r_cpu_rst;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overflow    = r_overflow;
  assign o_word_count  = r_count;

endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
- Sequences the instruction single-port RAM during program load.
- Accepts a byte stream from the debug UART receiver, assembles it into 32-bit instruction words and drives the RAM write port (wr_addr/data/wea).
- Holds the fetch side quiescent while loading: output register enable low, CPU held in reset.
- When the end-of-program marker word arrives, releases the CPU to run from address 0.

Parameters:
- RAM_WIDTH, 32, instruction word width; must be a multiple of 8.
- NB_DEPTH, 10, RAM address width; depth is 2**NB_DEPTH.
- END_MARKER, 32'hFFFF_FFFF, word value that terminates a load. The marker itself is never written to RAM.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE or RUN.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  byte-valid strobe, one cycle per byte.
- o_wr_addr  out  NB_DEPTH  RAM write address.
- o_wr_data  out  RAM_WIDTH  RAM write data.
- o_wea  out  1  RAM write enable, one-cycle pulse per word.
- o_regcea  out  1  RAM output register enable; 0 while loading.
- o_cpu_rst  out  1  pipeline reset; 1 unless in RUN.
- o_busy  out  1  1 in LOAD.
- o_done  out  1  1-cycle pulse on LOAD->RUN.
- o_overflow  out  1  sticky; set when a load fills the RAM. Cleared by i_start or i_rst.
- o_word_count  out  NB_DEPTH+1  words written in the current/last load.

Behaviour:
- Reset values:
  - o_wr_addr=0, o_wr_data=0, o_wea=0, o_regcea=0.
  - o_cpu_rst=1, o_busy=0, o_done=0, o_overflow=0, o_word_count=0.
  - Byte index=0; state IDLE.
- State IDLE:
  - CPU held in reset, o_regcea=0, bytes ignored.
  - i_start -> LOAD.
- State LOAD:
  - o_busy=1, o_cpu_rst=1, o_regcea=0.
  - Each i_rx_valid shifts i_rx_data into the assembly register, MSB first: the first byte lands in bits [31:24].
  - The byte index (2 bits) increments and wraps 3->0.
- Completing a word (4th byte accepted at cycle N):
  - If word == END_MARKER: no write; o_done=1 at N+1; state RUN at N+1.
  - Otherwise: at N+1, o_wea=1, o_wr_data=word, o_wr_addr=current address. The address and o_word_count then increment (visible at N+2).
- Overflow:
  - If the word just written is at address 2**NB_DEPTH-1, set o_overflow, pulse o_done, go to RUN.
  - The address never wraps to 0 within a load.
  - Bytes after that are ignored.
- State RUN:
  - o_cpu_rst=0, o_regcea=1, o_busy=0, bytes ignored.
  - i_start -> LOAD.
- Entering LOAD (from IDLE or RUN):
  - Address=0, byte index=0, o_word_count=0, o_overflow=0.
  - o_cpu_rst=1 and o_regcea=0 from the next cycle.
- i_start while in LOAD: ignored; the load continues.
- i_rx_valid in the same cycle as the i_start that enters LOAD: the byte is dropped. The first byte is taken from the next cycle onward.
- Partial word (1-3 bytes) pending: it stays pending indefinitely. There is no timeout; only i_rst or a completed word clears it.
- Reset mid-load:
  - Next cycle returns to IDLE with all reset values.
  - A pending o_wea pulse is suppressed.
  - RAM contents written so far are left as-is.
- o_wea is never asserted for two consecutive cycles: a new word needs 4 bytes, and bytes arrive at most one per cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - State encoding localparams: ST_IDLE=2'b00, ST_LOAD=2'b01, ST_RUN=2'b10.
  - END_MARKER default.
  - Bytes-per-word constant (RAM_WIDTH/8).
- One natural sub-module, byte_word_assembler:
  - Shift register plus byte index.
  - Outputs word plus a word_valid pulse, with clear input.
  - Reusable for the data-memory debug dump path.
- FSM, address/count counters and output registers stay in the top.

Test Plan:
- Reset, then idle 10 cycles:
  - o_cpu_rst=1, o_regcea=0, o_wea never 1, o_word_count=0.
  - Bytes sent in IDLE produce no write.
- i_start, then bytes 8C,01,00,04 then 00,00,00,00 then FF,FF,FF,FF:
  - Writes 32'h8C010004@0 and 32'h00000000@1 (one o_wea each, cycle after the 4th byte).
  - Marker is not written; o_done pulse; o_word_count=2; o_cpu_rst=0 and o_regcea=1 thereafter.
- From RUN, i_start, then one word 20010005 and the marker:
  - Address restarts at 0: write 32'h20010005@0.
  - o_word_count=1; CPU held in reset during the load.
- NB_DEPTH=2, send 4 non-marker words:
  - Writes at addresses 0..3; o_overflow=1, o_done pulse, RUN.
  - A 5th word produces no o_wea.
- Send bytes 12,34 then i_rst, then i_start and AA,BB,CC,DD + marker:
  - Write 32'hAABBCCDD@0; the stale partial bytes never appear.
- Back-to-back bytes (i_rx_valid every cycle) for 3 words + marker:
  - o_wea pulses spaced exactly 4 cycles apart.
  - i_start pulsed mid-load is ignored: addresses 0,1,2 and count=3.
